demux_256x1: RTL and testbench

DEMUX_256X1 -- requirements
Module: demux_256x1

---
 rtl/demux_256x1_if.sv | 26 ++
 rtl/demux_256x1.sv | 82 ++++++++
 tb/tb_demux_256x1.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/demux_256x1_if.sv
// Bus bundle for the serial-to-parallel demultiplexer: write-side controls
// plus the registered data word and fill-status outputs.
interface demux_256x1_if #(
    parameter int SEL_W = 8,
    parameter int N     = 256
);
    logic             in_bit;
    logic [SEL_W-1:0] sel;
    logic             wr_en;
    logic             auto;
    logic             clr;
    logic [N-1:0]     a_out;
    logic [SEL_W-1:0] ptr;
    logic             busy;
    logic             frame_done;

    modport master (
        output in_bit, sel, wr_en, auto, clr,
        input  a_out, ptr, busy, frame_done
    );

    modport slave (
        input  in_bit, sel, wr_en, auto, clr,
        output a_out, ptr, busy, frame_done
    );
endinterface

// File: rtl/demux_256x1.sv
// Routes a serial bit into an N-bit registered word, either at an addressed
// position or by auto-incrementing frame fill with a frame-complete pulse.
module demux_256x1 #(
    parameter int SEL_W = 8,
    parameter int N     = 256   // must equal 2**SEL_W
) (
    input  logic          clk,
    input  logic          rst_n,
    demux_256x1_if.slave  bus
);
    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

    state_t           state, next_state;
    logic [N-1:0]     a_out_q;
    logic [SEL_W-1:0] ptr_q;
    logic             frame_done_q;
    logic             busy_c;
    logic [SEL_W-1:0] wr_idx;
    logic             last_write;

    assign last_write = (state == FILL) && bus.wr_en && (ptr_q == LAST_IDX);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; clr overrides any write.
    // NOTE: next_state gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        if (bus.clr) begin
            next_state = IDLE;
        end else if (bus.wr_en) begin
            case (state)
                IDLE: if (bus.auto)  next_state = FILL;
                FILL: if (last_write) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Moore outputs and write-target selection.
    always_comb begin
        busy_c = (state == FILL);
        wr_idx = bus.sel;
        if (state == FILL)  wr_idx = ptr_q;
        else if (bus.auto)  wr_idx = '0;
    end

    // Data word, fill pointer and the one-cycle frame-complete pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out_q      <= '0;
            ptr_q        <= '0;
            frame_done_q <= 1'b0;
        end else if (bus.clr) begin
            a_out_q      <= '0;
            ptr_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= last_write;
            if (bus.wr_en) begin
                a_out_q[wr_idx] <= bus.in_bit;
                // ptr wraps to 0 naturally after N-1 since N == 2**SEL_W.
                if (state == FILL)  ptr_q <= ptr_q + SEL_W'(1);
                else if (bus.auto)  ptr_q <= SEL_W'(1);
            end
        end
    end

    assign bus.a_out      = a_out_q;
    assign bus.ptr        = ptr_q;
    assign bus.busy       = busy_c;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_demux_256x1.sv
// Randomized self-checking bench for demux_256x1 against an array-based
// model of the addressed / auto-fill frame behaviour.
module tb_demux_256x1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    demux_256x1_if #(.SEL_W(8), .N(256)) dif ();
    demux_256x1 #(.SEL_W(8), .N(256)) dut (.clk(clk), .rst_n(rst_n), .bus(dif));

    always #5 clk = ~clk;

    // Reference model: a bit array, an integer fill index and a filling flag.
    bit exp_mem [256];
    int exp_ptr;
    bit exp_filling;
    bit exp_done;

    function automatic logic [255:0] exp_vec();
        logic [255:0] v;
        for (int i = 0; i < 256; i++) v[i] = exp_mem[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) exp_mem[i] = 1'b0;
        exp_ptr = 0; exp_filling = 1'b0; exp_done = 1'b0;
    endtask

    task automatic model_apply(bit wr, bit au, int s, bit b, bit c);
        if (c) begin
            model_reset();
        end else begin
            exp_done = 1'b0;
            if (wr) begin
                if (!exp_filling) begin
                    if (au) begin
                        exp_mem[0] = b; exp_ptr = 1; exp_filling = 1'b1;
                    end else begin
                        exp_mem[s] = b;
                    end
                end else begin
                    exp_mem[exp_ptr] = b;
                    exp_ptr = (exp_ptr + 1) % 256;
                    if (exp_ptr == 0) begin
                        exp_filling = 1'b0; exp_done = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic drive(bit wr, bit au, int s, bit b, bit c);
        dif.wr_en = wr; dif.auto = au; dif.sel = 8'(s); dif.in_bit = b; dif.clr = c;
    endtask

    // One clock: model consumes the values sampled at the edge; outputs read #1 later.
    task automatic tick();
        @(posedge clk);
        model_apply(dif.wr_en, dif.auto, int'(dif.sel), dif.in_bit, dif.clr);
        #1;
    endtask

    task automatic do_clr();
        drive(0, 0, 0, 0, 1); tick(); drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(1, 0, 3, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++; if (dif.a_out !== '0) begin errors++; $display("FAIL reset_a_out got %h want 0", dif.a_out); end
        checks++; if (dif.ptr !== 8'd0) begin errors++; $display("FAIL reset_ptr got %0d want 0", dif.ptr); end
        checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", dif.busy); end
        checks++; if (dif.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", dif.frame_done); end
        @(negedge clk); rst_n = 1'b1;
        drive(1, 0, 7, 1, 0);
        tick();
        checks++; if (dif.a_out !== exp_vec()) begin errors++; $display("FAIL first_write got %h want %h", dif.a_out, exp_vec()); end
        drive(0, 0, 0, 0, 0);
        do_clr();
    endtask

    task automatic test_addressed();
        logic [255:0] want;
        drive(1, 0, 8'hA5, 1, 0); tick(); drive(0, 0, 0, 0, 0);
        want = '0; want[165] = 1'b1;
        checks++; if (dif.a_out !== want) begin errors++; $display("FAIL addr_a5 got %h want %h", dif.a_out, want); end
        checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL addr_busy got %b want 0", dif.busy); end
        checks++; if (dif.ptr !== 8'd0) begin errors++; $display("FAIL addr_ptr got %0d want 0", dif.ptr); end
        for (int i = 0; i < 40; i++) begin
            drive(bit'($urandom_range(0, 1)), 0, int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), 0);
            tick();
            checks++; if (dif.a_out !== exp_vec()) begin errors++; $display("FAIL addr_rand[%0d] got %h want %h", i, dif.a_out, exp_vec()); end
        end
        drive(0, 0, 0, 0, 0);
        do_clr();
    endtask

    task automatic test_full_frame();
        int idx = 0;
        int pulses = 0;
        int guard = 0;
        while (idx < 256 && guard < 2000) begin
            guard++;
            if ($urandom_range(0, 3) == 0) drive(0, 1, int'($urandom_range(0, 255)), 1, 0);
            else begin drive(1, 1, int'($urandom_range(0, 255)), bit'(idx % 2), 0); idx++; end
            tick();
            if (dif.frame_done === 1'b1) pulses++;
            checks++; if (dif.frame_done !== exp_done || dif.busy !== exp_filling || dif.ptr !== 8'(exp_ptr)) begin
                errors++; $display("FAIL frame_step[%0d] done/busy/ptr got %b/%b/%0d want %b/%b/%0d",
                                   idx, dif.frame_done, dif.busy, dif.ptr, exp_done, exp_filling, exp_ptr);
            end
        end
        checks++; if (idx != 256) begin errors++; $display("FAIL frame_budget got %0d writes want 256", idx); end
        drive(0, 0, 0, 0, 0); tick();
        checks++; if (dif.a_out !== {128{2'b10}}) begin errors++; $display("FAIL frame_word got %h want aaaa..aaaa", dif.a_out); end
        checks++; if (dif.ptr !== 8'd0 || dif.busy !== 1'b0) begin errors++; $display("FAIL frame_end ptr/busy got %0d/%b want 0/0", dif.ptr, dif.busy); end
        checks++; if (dif.frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_len got %b want 0", dif.frame_done); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL frame_pulses got %0d want 1", pulses); end
        do_clr();
    endtask

    task automatic test_auto_ignored();
        for (int i = 0; i < 10; i++) begin drive(1, 1, 0, bit'($urandom_range(0, 1)), 0); tick(); end
        for (int i = 10; i < 255; i++) begin
            drive(1, 0, 8'hFF, 1, 0); tick();
            checks++; if (dif.ptr !== 8'(i + 1) || dif.a_out[255] !== 1'b0) begin
                errors++; $display("FAIL autoign[%0d] ptr/bit255 got %0d/%b want %0d/0", i, dif.ptr, dif.a_out[255], i + 1);
            end
        end
        drive(1, 0, 8'hFF, 1, 0); tick(); drive(0, 0, 0, 0, 0);
        checks++; if (dif.a_out[255] !== 1'b1 || dif.frame_done !== 1'b1) begin
            errors++; $display("FAIL autoign_last bit255/done got %b/%b want 1/1", dif.a_out[255], dif.frame_done);
        end
        checks++; if (dif.a_out !== exp_vec()) begin errors++; $display("FAIL autoign_word got %h want %h", dif.a_out, exp_vec()); end
        do_clr();
    endtask

    task automatic test_clr_collision();
        for (int i = 0; i < 255; i++) begin drive(1, 1, 0, 1, 0); tick(); end
        checks++; if (dif.ptr !== 8'd255 || dif.busy !== 1'b1) begin errors++; $display("FAIL clr_pre ptr/busy got %0d/%b want 255/1", dif.ptr, dif.busy); end
        drive(1, 1, 0, 1, 1); tick(); drive(0, 0, 0, 0, 0);
        checks++; if (dif.a_out !== '0 || dif.ptr !== 8'd0 || dif.busy !== 1'b0 || dif.frame_done !== 1'b0) begin
            errors++; $display("FAIL clr_coll a_out_zero/ptr/busy/done got %b/%0d/%b/%b want 1/0/0/0",
                               dif.a_out == '0, dif.ptr, dif.busy, dif.frame_done);
        end
        tick();
        checks++; if (dif.frame_done !== 1'b0) begin errors++; $display("FAIL clr_coll_late got %b want 0", dif.frame_done); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 100; i++) begin drive(1, 1, 0, bit'($urandom_range(0, 1)), 0); tick(); end
        drive(0, 0, 0, 0, 0);
        checks++; if (dif.ptr !== 8'd100) begin errors++; $display("FAIL arst_pre ptr got %0d want 100", dif.ptr); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (dif.a_out !== '0 || dif.ptr !== 8'd0 || dif.busy !== 1'b0 || dif.frame_done !== 1'b0) begin
            errors++; $display("FAIL arst_async a_out_zero/ptr/busy/done got %b/%0d/%b/%b want 1/0/0/0",
                               dif.a_out == '0, dif.ptr, dif.busy, dif.frame_done);
        end
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        drive(1, 0, 0, 1, 0); tick(); drive(0, 0, 0, 0, 0);
        checks++; if (dif.a_out !== 256'd1 || dif.busy !== 1'b0) begin
            errors++; $display("FAIL arst_after a_out/busy got %h/%b want 1/0", dif.a_out, dif.busy);
        end
        tick();
        checks++; if (dif.frame_done !== 1'b0) begin errors++; $display("FAIL arst_nodone got %b want 0", dif.frame_done); end
        do_clr();
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        int pulses = 0;
        for (int c = 1; c <= 512; c++) begin
            drive(1, 1, int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), 0);
            tick();
            if (dif.frame_done === 1'b1) begin
                pulses++;
                if (first < 0) first = c; else if (second < 0) second = c;
            end
            checks++; if (dif.frame_done !== exp_done || dif.a_out !== exp_vec()) begin
                errors++; $display("FAIL b2b[%0d] done got %b want %b, word_ok %b", c, dif.frame_done, exp_done, dif.a_out === exp_vec());
            end
        end
        drive(0, 0, 0, 0, 0); tick();
        checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
        checks++; if (second - first != 256) begin errors++; $display("FAIL b2b_spacing got %0d want 256", second - first); end
        checks++; if (dif.busy !== 1'b0 || dif.ptr !== 8'd0) begin errors++; $display("FAIL b2b_end busy/ptr got %b/%0d want 0/0", dif.busy, dif.ptr); end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_addressed();
        test_full_frame();
        test_auto_ignored();
        test_clr_collision();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
